axi4_rd_mem_slave: RTL and testbench
====================================

// Module: axi4_rd_mem_slave
// PURPOSE
//  AXI4 read-channel responder: accepts AR bursts from a master, reads a single-port sync-read
//  memory (1-cycle latency), returns R beats with RID/RRESP/RLAST.
//  Sits between an AXI4 read master (e.g. DMA, CPU port) and on-chip RAM/register arrays.
//  One burst at a time; RREADY backpressure absorbed by a 2-entry output buffer.
// PARAMETERS
//  ID_W    1   ID width (ARID/RID)
//  ADDR_W  32  byte address width
//  DATA_W  32  data width, power of 2, 8..1024; LSB = log2(DATA_W/8)
//  MEM_AW  10  memory word-address width; mem_addr = addr[MEM_AW+LSB-1:LSB] (upper bits ignored)
// PORTS
//  ACLK      in   1         clock; one clock; reset is synchronous and active-high
//  ARESET    in   1         sync reset, active-high
//  ARID      in   ID_W      burst ID
//  ARVALID   in   1         AR valid
//  ARREADY   out  1         AR ready
//  ARADDR    in   ADDR_W    start byte address
//  ARLEN     in   8         beats-1
//  ARSIZE    in   3         log2 bytes/beat
//  ARBURST   in   2         00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  RID       out  ID_W      echo of ARID
//  RVALID    out  1         R valid
//  RREADY    in   1         R ready
//  RDATA     out  DATA_W    full word; master selects lanes for narrow sizes
//  RRESP     out  2         00 OKAY, 10 SLVERR
//  RLAST     out  1         final beat
//  mem_rd_en out  1         memory read strobe
//  mem_addr  out  MEM_AW    memory word address
//  mem_rdata in   DATA_W    read data, valid the cycle after mem_rd_en
// BEHAVIOUR
//  Reset: all outputs 0 (incl. ARREADY); state IDLE, buffer empty, in-flight read dropped.
//  IDLE: ARREADY=1 from first cycle after reset. On ARVALID&ARREADY (cycle N): latch ID/addr/
//   len/size/burst, ARREADY=0 at N+1, go ACTIVE. ARREADY stays 0 outside IDLE.
//  Error check at accept: SLVERR if ARSIZE>LSB, ARBURST=11, or WRAP with ARLEN not in {1,3,7,15}.
//   Error bursts: no mem reads; len+1 beats, RDATA=0, RRESP=10, normal RLAST.
//  ACTIVE: issue mem_rd_en when (buffer entries + in-flight read) < 2 and reads remain.
//   First mem_rd_en at N+1, first RVALID at N+2. RREADY held 1: one beat/cycle, last at N+2+len.
//   Address after each issued read: FIXED unchanged; INCR addr+(1<<size); WRAP as INCR but
//   wrapped within an aligned (len+1)<<size byte window. Unaligned INCR/FIXED start: only the
//   first beat uses the unaligned address; INCR aligns to size after it. INCR runs past the
//   MEM_AW word range wrap modulo 2^MEM_AW.
//  Buffer: 2-entry FIFO of {data,resp,last}; RVALID = not empty; RID constant for the burst.
//   Head stable while RVALID & !RREADY. Push and pop in the same cycle keep the count unchanged.
//  Done: on RVALID&RREADY&RLAST go IDLE; ARREADY=1 the next cycle (1 idle cycle between bursts).
//  ARESET mid-burst: next edge returns to the reset values above; the burst is abandoned.
// TESTING
//  1 INCR ARADDR=0x100 LEN=3 SIZE=2 ID=1, RREADY=1 -> mem_addr 0x40..0x43 at N+1..N+4;
//    4 beats at N+2..N+5, RID=1, RRESP=00, RLAST on beat 4 only.
//  2 WRAP ARADDR=0x108 LEN=3 SIZE=2 -> mem_addr order 0x42,0x43,0x40,0x41; data order matches.
//  3 FIXED ARADDR=0x20 LEN=2 SIZE=2 -> mem_addr 0x08 three times, 3 beats, RLAST on 3rd.
//  4 INCR LEN=15, RREADY low 5 cycles mid-burst then toggling 1/0 -> all 16 words in order, none
//    dropped or duplicated. Never >2 reads outstanding. RDATA/RLAST stable while stalled.
//  5 ARSIZE=3 (DATA_W=32) LEN=1 -> mem_rd_en never 1; 2 beats RRESP=10 RDATA=0 RLAST on 2nd.
//    ARBURST=11 -> same. Next legal burst returns OKAY.
//  6 ARESET 1 cycle after 2nd beat of LEN=7 -> next cycle RVALID=0 ARREADY=0 mem_rd_en=0;
//    ARREADY=1 after release; new INCR burst from 0x0 completes correctly.

Source files
------------

// File: rtl/axi4_rd_mem_slave.sv
// rtl/axi4_rd_mem_slave.sv - AXI4 read-channel responder over a 1-cycle sync-read memory
// One burst at a time; R beats drain through a 2-entry buffer with fall-through when empty.
module axi4_rd_mem_slave #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   ARID,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  output logic [ID_W-1:0]   RID,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LSB = $clog2(DATA_W / 8);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_arready;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_err;
  logic [8:0]        r_rd_left;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [DATA_W-1:0] r_buf_data [2];
  logic [1:0]        r_buf_resp [2];
  logic              r_buf_last [2];
  logic              r_wptr, r_rptr;
  logic [1:0]        r_count;

  logic              w_ar_hs, w_ar_err, w_issue, w_empty, w_rvalid;
  logic              w_pop, w_push, w_pop_buf, w_done;
  logic [DATA_W-1:0] w_in_data, w_head_data;
  logic [1:0]        w_in_resp, w_head_resp;
  logic              w_head_last;
  logic [ADDR_W-1:0] w_beat_bytes, w_aligned, w_incr, w_wrap_mask, w_wrap, w_addr_nxt;

  assign w_ar_hs  = ARVALID & r_arready;
  assign w_ar_err = (ARSIZE > 3'(LSB)) || (ARBURST == 2'b11) ||
                    ((ARBURST == 2'b10) && !((ARLEN == 8'd1) || (ARLEN == 8'd3) ||
                                             (ARLEN == 8'd7) || (ARLEN == 8'd15)));

  // Reads are throttled so the buffer can always absorb every outstanding read.
  assign w_issue = (r_state == S_ACTIVE) && (r_rd_left != 9'd0) &&
                   ((r_count + {1'b0, r_inflight}) < 2'd2);

  assign w_in_data = r_err ? '0 : mem_rdata;
  assign w_in_resp = r_err ? 2'b10 : 2'b00;
  assign w_empty   = (r_count == 2'd0);
  assign w_rvalid  = !w_empty || r_inflight;

  // Empty buffer: the returning read word is presented directly on R.
  assign w_head_data = w_empty ? w_in_data       : r_buf_data[r_rptr];
  assign w_head_resp = w_empty ? w_in_resp       : r_buf_resp[r_rptr];
  assign w_head_last = w_empty ? r_inflight_last : r_buf_last[r_rptr];

  assign w_pop     = w_rvalid & RREADY;
  assign w_push    = r_inflight & !(w_empty & RREADY);
  assign w_pop_buf = w_pop & !w_empty;
  assign w_done    = w_pop & w_head_last;

  assign w_beat_bytes = ADDR_W'(1) << r_size;
  assign w_aligned    = r_addr & ~(w_beat_bytes - ADDR_W'(1));
  assign w_incr       = w_aligned + w_beat_bytes;
  assign w_wrap_mask  = ((ADDR_W'(r_len) + ADDR_W'(1)) << r_size) - ADDR_W'(1);
  assign w_wrap       = (r_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);

  always_comb begin
    w_addr_nxt = w_incr;
    case (r_burst)
      2'b00:   w_addr_nxt = r_addr;
      2'b10:   w_addr_nxt = w_wrap;
      default: w_addr_nxt = w_incr;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_ar_hs) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_done)  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state         <= S_IDLE;
      r_arready       <= 1'b0;
      r_id            <= '0;
      r_addr          <= '0;
      r_len           <= '0;
      r_size          <= '0;
      r_burst         <= '0;
      r_err           <= 1'b0;
      r_rd_left       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wptr          <= 1'b0;
      r_rptr          <= 1'b0;
      r_count         <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_arready <= (w_state_nxt == S_IDLE);
      if (w_ar_hs) begin
        r_id      <= ARID;
        r_addr    <= ARADDR;
        r_len     <= ARLEN;
        r_size    <= ARSIZE;
        r_burst   <= ARBURST;
        r_err     <= w_ar_err;
        r_rd_left <= {1'b0, ARLEN} + 9'd1;
      end else if (w_issue) begin
        r_addr    <= w_addr_nxt;
        r_rd_left <= r_rd_left - 9'd1;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= (r_rd_left == 9'd1);
      if (w_push) begin
        r_buf_data[r_wptr] <= w_in_data;
        r_buf_resp[r_wptr] <= w_in_resp;
        r_buf_last[r_wptr] <= r_inflight_last;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop_buf) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop_buf};
    end
  end

  assign ARREADY   = r_arready;
  assign RID       = r_id;
  assign RVALID    = w_rvalid;
  assign RDATA     = w_rvalid ? w_head_data : '0;
  assign RRESP     = w_rvalid ? w_head_resp : 2'b00;
  assign RLAST     = w_rvalid & w_head_last;
  assign mem_rd_en = w_issue & ~r_err;
  assign mem_addr  = r_addr[MEM_AW+LSB-1:LSB];

endmodule

// File: tb/tb_axi4_rd_mem_slave.sv
// tb/tb_axi4_rd_mem_slave.sv - bench for axi4_rd_mem_slave against a per-beat address model
module tb_axi4_rd_mem_slave;

  logic        ACLK, ARESET, ARVALID, ARREADY, RVALID, RREADY, RLAST, mem_rd_en;
  logic [0:0]  ARID, RID;
  logic [31:0] ARADDR, RDATA, mem_rdata;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST, RRESP;
  logic [9:0]  mem_addr;

  axi4_rd_mem_slave dut (
    .ACLK(ACLK), .ARESET(ARESET), .ARID(ARID), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RID(RID), .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  logic [31:0] mem [0:1023];
  always @(posedge ACLK) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t      q_beat[$];
  logic [9:0] q_addr[$];
  logic [0:0] exp_id;
  int checks, errors, cyc, rr_mode, rr_ctr, issued, popped;
  int accept_cyc, first_rd, first_rv, last_cyc;
  logic accepted, done, busy, stall_v, s_last;
  logic [31:0] s_data;
  logic [1:0]  s_resp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] beat_word(input logic [31:0] addr, input int len,
                                           input int size, input int burst, input int i);
    longint unsigned bytes, aligned, a, win, lower;
    bytes   = 64'd1 << size;
    aligned = longint'(addr) & ~(bytes - 1);
    if (burst == 0) a = longint'(addr);
    else if (burst == 1) a = (i == 0) ? longint'(addr) : aligned + longint'(i) * bytes;
    else begin
      win   = longint'(len + 1) * bytes;
      lower = (aligned / win) * win;
      a     = aligned + longint'(i) * bytes;
      if (a >= lower + win) a = a - win;
    end
    return 10'(a >> 2);
  endfunction

  task automatic monitor();
    beat_t b;
    if (ARESET) begin
      q_beat.delete();
      q_addr.delete();
      issued  = 0;
      popped  = 0;
      stall_v = 1'b0;
      return;
    end
    if (stall_v) begin
      check("stall_rvalid", RVALID, 1);
      check("stall_rdata", RDATA, s_data);
      check("stall_rresp", RRESP, s_resp);
      check("stall_rlast", RLAST, s_last);
    end
    if (busy) begin
      check("arready_busy", ARREADY, 0);
      check("outstanding_le2", (issued - popped) <= 2, 1);
    end
    if (mem_rd_en) begin
      if (q_addr.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_addr", mem_addr, q_addr.pop_front());
      if (first_rd < 0) first_rd = cyc;
      issued++;
    end
    if (RVALID && RREADY) begin
      if (first_rv < 0) first_rv = cyc;
      if (q_beat.size() == 0) check("beat_unexpected", 1, 0);
      else begin
        b = q_beat.pop_front();
        check("rdata", RDATA, b.data);
        check("rresp", RRESP, b.resp);
        check("rlast", RLAST, b.last);
        check("rid", RID, exp_id);
      end
      popped++;
      if (RLAST) begin
        done     = 1'b1;
        last_cyc = cyc;
      end
    end
    stall_v = RVALID && !RREADY;
    s_data  = RDATA;
    s_resp  = RRESP;
    s_last  = RLAST;
    if (ARVALID && ARREADY) begin
      accepted   = 1'b1;
      accept_cyc = cyc;
      issued     = 0;
      popped     = 0;
    end
  endtask

  task automatic drive_rready();
    case (rr_mode)
      0:       RREADY = 1'b1;
      1:       RREADY = 1'($urandom_range(0, 1));
      default: RREADY = (rr_ctr < 4) ? 1'b1 : (rr_ctr < 9) ? 1'b0 : 1'(rr_ctr & 1);
    endcase
  endtask

  task automatic tick();
    @(negedge ACLK);
    monitor();
    @(posedge ACLK);
    cyc++;
    rr_ctr++;
    #1;
    drive_rready();
  endtask

  task automatic do_burst(input logic [0:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int mode, input int abort_at);
    bit   err;
    int   n, w;
    logic aborting;
    beat_t b;
    err = (size > 2) || (burst == 3) ||
          ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    for (int i = 0; i <= len; i++) begin
      w = int'(beat_word(addr, len, size, burst, i));
      if (!err) q_addr.push_back(10'(w));
      b.data = err ? 32'h0 : mem[w];
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == len);
      q_beat.push_back(b);
    end
    exp_id   = id;
    rr_mode  = mode;
    rr_ctr   = 0;
    drive_rready();
    accepted = 1'b0;
    done     = 1'b0;
    aborting = 1'b0;
    first_rd = -1;
    first_rv = -1;
    ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
    ARVALID = 1'b1;
    n = 0;
    while (!accepted && n < 20) begin tick(); n++; end
    ARVALID = 1'b0;
    check("ar_accept", accepted, 1);
    busy = 1'b1;
    n = 0;
    while (!done && !aborting && n < 3000) begin
      tick();
      n++;
      if (abort_at >= 0 && popped == abort_at) aborting = 1'b1;
    end
    busy = 1'b0;
    if (aborting) begin
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      check("abort_rvalid", RVALID, 0);
      check("abort_arready", ARREADY, 0);
      check("abort_rd_en", mem_rd_en, 0);
      tick();
      check("abort_arready_rel", ARREADY, 1);
      return;
    end
    check("burst_done", done, 1);
    check("queues_drained", q_addr.size() + q_beat.size(), 0);
    check("arready_after_done", ARREADY, 1);
    if (mode == 0 && !err) begin
      check("first_rd_lat", first_rd - accept_cyc, 1);
      check("first_rv_lat", first_rv - accept_cyc, 2);
      check("last_beat_lat", last_cyc - accept_cyc, 2 + len);
    end
    q_addr.delete();
    q_beat.delete();
  endtask

  initial begin
    int bu, sz, ln;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    checks = 0; errors = 0; cyc = 0; rr_mode = 0; rr_ctr = 0; issued = 0; popped = 0;
    busy = 1'b0; stall_v = 1'b0; done = 1'b0; accepted = 1'b0; exp_id = '0;
    s_data = '0; s_resp = '0; s_last = 1'b0;
    accept_cyc = 0; first_rd = -1; first_rv = -1; last_cyc = 0;
    ARESET = 1'b1; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0;
    ARBURST = '0; RREADY = 1'b1;
    tick(); tick(); tick();
    check("rst_arready", ARREADY, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_rlast", RLAST, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_rresp", RRESP, 0);
    check("rst_rid", RID, 0);
    ARESET = 1'b0;
    tick();
    check("arready_post_reset", ARREADY, 1);

    do_burst(1'b1, 32'h100, 3, 2, 1, 0, -1);
    do_burst(1'b0, 32'h108, 3, 2, 2, 0, -1);
    do_burst(1'b1, 32'h020, 2, 2, 0, 0, -1);
    do_burst(1'b0, 32'h040, 15, 2, 1, 2, -1);
    do_burst(1'b1, 32'h000, 1, 3, 1, 0, -1);
    do_burst(1'b0, 32'h010, 1, 2, 3, 0, -1);
    do_burst(1'b1, 32'h200, 3, 2, 1, 0, -1);
    do_burst(1'b0, 32'h103, 3, 2, 1, 0, -1);
    do_burst(1'b1, 32'hFF8, 3, 2, 1, 0, -1);
    do_burst(1'b0, 32'h300, 7, 2, 1, 0, 2);
    do_burst(1'b1, 32'h000, 3, 2, 1, 0, -1);

    for (int k = 0; k < 30; k++) begin
      bu = $urandom_range(0, 3);
      sz = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      if (bu == 2) ln = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15)
                                                     : (2 << $urandom_range(0, 3)) - 1;
      else ln = $urandom_range(0, 20);
      do_burst(1'($urandom_range(0, 1)), $urandom, ln, sz, bu, $urandom_range(0, 2), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
